// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants for the two-master RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic M_HOST = 1'b0;
    localparam logic M_DMA  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter_if
// Description : Toggle-handshake bus for both masters and the RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int ADDR_BITS = 17,
    parameter int DATA_BITS = 8
);
    logic [ADDR_BITS-1:0] m0_a;
    logic [DATA_BITS-1:0] m0_d;
    logic                 m0_we;
    logic                 m0_req;
    logic                 m0_ack;
    logic [DATA_BITS-1:0] m0_q;

    logic [ADDR_BITS-1:0] m1_a;
    logic [DATA_BITS-1:0] m1_d;
    logic                 m1_we;
    logic                 m1_req;
    logic                 m1_ack;
    logic [DATA_BITS-1:0] m1_q;

    logic [ADDR_BITS-1:0] ram_a;
    logic [DATA_BITS-1:0] ram_d;
    logic                 ram_we;
    logic                 ram_req;
    logic                 ram_ack;
    logic [DATA_BITS-1:0] ram_q;

    // Environment side: both requesters plus the RAM controller.
    modport master (
        output m0_a, m0_d, m0_we, m0_req,
        input  m0_ack, m0_q,
        output m1_a, m1_d, m1_we, m1_req,
        input  m1_ack, m1_q,
        input  ram_a, ram_d, ram_we, ram_req,
        output ram_ack, ram_q
    );

    modport slave (
        input  m0_a, m0_d, m0_we, m0_req,
        output m0_ack, m0_q,
        input  m1_a, m1_d, m1_we, m1_req,
        output m1_ack, m1_q,
        output ram_a, ram_d, ram_we, ram_req,
        input  ram_ack, ram_q
    );
endinterface
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pick
// Description : Combinational winner select between two pending masters.
//               RAM_ARB_ROUND_ROBIN_EN: ties go to the master that was not
//               the last owner; otherwise master 0 always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  wire logic [1:0] i_pend,
    input  wire logic       i_last_owner,
    output logic            o_valid,
    output logic            o_idx
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam logic c_ROUND_ROBIN = 1'b1;
`else
    localparam logic c_ROUND_ROBIN = 1'b0;
`endif

    always_comb begin
        o_valid = |i_pend;
        o_idx   = M_HOST;
        if (&i_pend) begin
            o_idx = c_ROUND_ROBIN ? ~i_last_owner : M_HOST;
        end else if (i_pend[M_DMA]) begin
            o_idx = M_DMA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Serialises two toggle-handshake masters onto one RAM port,
//               holding the winner's request stable for the whole access.
//               Tie policy selected by RAM_ARB_ROUND_ROBIN_EN (in ram_arb_pick).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 17,
    parameter int DATA_BITS = 8
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    ram_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              owner
);

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic                 r_m0_ack;
    logic                 r_m1_ack;
    logic [DATA_BITS-1:0] r_m0_q;
    logic [DATA_BITS-1:0] r_m1_q;
    logic [ADDR_BITS-1:0] r_ram_a;
    logic [DATA_BITS-1:0] r_ram_d;
    logic                 r_ram_we;
    logic                 r_ram_req;
    logic                 r_owner;

    logic [1:0]           w_pend;
    logic                 w_pick_valid;
    logic                 w_pick_idx;
    logic                 w_grant;
    logic                 w_done;

    // A master is pending while its request toggle differs from its ack toggle.
    assign w_pend = {bus.m1_req ^ r_m1_ack, bus.m0_req ^ r_m0_ack};

    ram_arb_pick u_pick (
        .i_pend       (w_pend),
        .i_last_owner (r_owner),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.ram_ack == r_ram_req) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m0_ack  <= 1'b0;
            r_m1_ack  <= 1'b0;
            r_m0_q    <= '0;
            r_m1_q    <= '0;
            r_ram_a   <= '0;
            r_ram_d   <= '0;
            r_ram_we  <= 1'b0;
            r_ram_req <= 1'b0;
            r_owner   <= M_HOST;
        end else begin
            // Master inputs are only looked at here; the RAM side stays frozen until the next grant.
            if (w_grant) begin
                r_ram_a   <= (w_pick_idx == M_DMA) ? bus.m1_a  : bus.m0_a;
                r_ram_d   <= (w_pick_idx == M_DMA) ? bus.m1_d  : bus.m0_d;
                r_ram_we  <= (w_pick_idx == M_DMA) ? bus.m1_we : bus.m0_we;
                r_ram_req <= ~r_ram_req;
                r_owner   <= w_pick_idx;
            end
            if (w_done) begin
                if (r_owner == M_DMA) begin
                    r_m1_ack <= ~r_m1_ack;
                    if (!r_ram_we) begin
                        r_m1_q <= bus.ram_q;
                    end
                end else begin
                    r_m0_ack <= ~r_m0_ack;
                    if (!r_ram_we) begin
                        r_m0_q <= bus.ram_q;
                    end
                end
            end
        end
    end

    assign bus.m0_ack  = r_m0_ack;
    assign bus.m0_q    = r_m0_q;
    assign bus.m1_ack  = r_m1_ack;
    assign bus.m1_q    = r_m1_q;
    assign bus.ram_a   = r_ram_a;
    assign bus.ram_d   = r_ram_d;
    assign bus.ram_we  = r_ram_we;
    assign bus.ram_req = r_ram_req;

    assign busy  = (r_state == ST_BUSY);
    assign owner = r_owner;

endmodule
`default_nettype wire
